controlador_irrigacao: RTL

- Sequences irrigation and tank refill from the sensor switches: umidadeAr, umidadeSolo, temperatura, nivelDagua.
- Drives three valves, an alarm and a sensor-error flag.
- Exports remaining cycle time and state so the display/stopwatch path can show irrigation time.
- Sits beside the frequency divider and uses its one-second strobe.

---
 rtl/irrigacao_pkg.sv | 27 ++
 rtl/controlador_irrigacao_decodificador_nivel.sv | 24 ++
 rtl/controlador_irrigacao.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/irrigacao_pkg.sv
// Shared types and constants for the irrigation controller.
package irrigacao_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        OCIOSO     = 3'd0,
        GOTEJANDO  = 3'd1,
        ASPERSANDO = 3'd2,
        PAUSA      = 3'd3,
        ERRO       = 3'd4
    } estado_t;

    typedef enum logic [2:0] {
        VAZIO    = 3'd0,
        BAIXO    = 3'd1,
        MEDIO    = 3'd2,
        CHEIO    = 3'd3,
        INVALIDO = 3'd4
    } nivel_t;

    localparam logic [2:0] COD_VAZIO = 3'b000;
    localparam logic [2:0] COD_BAIXO = 3'b001;
    localparam logic [2:0] COD_MEDIO = 3'b011;
    localparam logic [2:0] COD_CHEIO = 3'b111;

endpackage

// File: rtl/controlador_irrigacao_decodificador_nivel.sv
// Thermometer level code to level enum; non-thermometer codes flag invalid.
module decodificador_nivel
    import irrigacao_pkg::*;
(
    input  logic [2:0] codigo,
    output nivel_t     nivel,
    output logic       invalido
);

    always_comb begin
        invalido = 1'b0;
        case (codigo)
            COD_VAZIO: nivel = VAZIO;
            COD_BAIXO: nivel = BAIXO;
            COD_MEDIO: nivel = MEDIO;
            COD_CHEIO: nivel = CHEIO;
            default: begin
                nivel    = INVALIDO;
                invalido = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/controlador_irrigacao.sv
// Irrigation/refill sequencer. Optional FILTRO_SENSOR_EN debounces sensors on the 1 s strobe.
// state      | meaning
// OCIOSO     | idle, waiting for dry soil
// GOTEJANDO  | drip valve open, counting T_GOTEJAMENTO
// ASPERSANDO | sprinkler valve open, counting T_ASPERSAO
// PAUSA      | mandatory rest, sensors ignored
// ERRO       | invalid level code, everything closed
module controlador_irrigacao
    import irrigacao_pkg::*;
#(
    parameter int T_GOTEJAMENTO = 20,
    parameter int T_ASPERSAO    = 10,
    parameter int T_PAUSA       = 5
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             umSegundo,
    input  logic             umidadeAr,
    input  logic             umidadeSolo,
    input  logic             temperatura,
    input  logic [2:0]       nivelDagua,
    output logic             valvulaGotejamento,
    output logic             valvulaAspersao,
    output logic             valvulaEntrada,
    output logic             alarme,
    output logic             erroSensor,
    output logic [2:0]       estado,
    output logic [CNT_W-1:0] tempoRestante,
    output logic [3:0]       leds
);

    logic [5:0] s1_q, s1_d, s2_q, s2_d, sens;

    assign s1_d = {umidadeAr, umidadeSolo, temperatura, nivelDagua};
    assign s2_d = s1_q;

`ifdef FILTRO_SENSOR_EN
    logic [5:0] amostra_q, amostra_d, filt_q, filt_d, estavel;

    // Sensor bits settle individually; the level code only as a whole word.
    always_comb begin
        estavel[5:3] = ~(s2_q[5:3] ^ amostra_q[5:3]);
        estavel[2:0] = {3{s2_q[2:0] == amostra_q[2:0]}};
        amostra_d    = amostra_q;
        filt_d       = filt_q;
        if (umSegundo) begin
            amostra_d = s2_q;
            filt_d    = (s2_q & estavel) | (filt_q & ~estavel);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            amostra_q <= '0;
            filt_q    <= '0;
        end else begin
            amostra_q <= amostra_d;
            filt_q    <= filt_d;
        end
    end

    assign sens = filt_q;
`else
    assign sens = s2_q;
`endif

    logic   ar_s, solo_s, temp_s, invalido;
    nivel_t nivel;

    assign {ar_s, solo_s, temp_s} = sens[5:3];

    decodificador_nivel u_decodificador_nivel (
        .codigo   (sens[2:0]),
        .nivel    (nivel),
        .invalido (invalido)
    );

    estado_t          estado_q, estado_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gote_q, gote_d, asp_q, asp_d, ent_q, ent_d;
    logic             alarme_q, alarme_d, erro_q, erro_d;

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        if (invalido) begin
            estado_d = ERRO;
            cnt_d    = '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (!solo_s && !ar_s && !temp_s && nivel >= MEDIO) begin
                        estado_d = ASPERSANDO;
                        cnt_d    = CNT_W'(T_ASPERSAO);
                    end else if (!solo_s && nivel >= BAIXO) begin
                        estado_d = GOTEJANDO;
                        cnt_d    = CNT_W'(T_GOTEJAMENTO);
                    end
                end
                GOTEJANDO, ASPERSANDO: begin
                    if (solo_s || nivel == VAZIO ||
                        (estado_q == ASPERSANDO && nivel < MEDIO)) begin
                        estado_d = PAUSA;
                        cnt_d    = CNT_W'(T_PAUSA);
                    end else if (umSegundo) begin
                        if (cnt_q <= CNT_W'(1)) begin
                            estado_d = PAUSA;
                            cnt_d    = CNT_W'(T_PAUSA);
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                PAUSA: begin
                    if (umSegundo) begin
                        if (cnt_q <= CNT_W'(1)) begin
                            estado_d = OCIOSO;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    estado_d = OCIOSO;
                    cnt_d    = '0;
                end
            endcase
        end
    end

    // Inlet valve has hysteresis: holds its value while the tank is at MEDIO.
    always_comb begin
        gote_d   = (estado_d == GOTEJANDO);
        asp_d    = (estado_d == ASPERSANDO);
        erro_d   = (estado_d == ERRO);
        alarme_d = !invalido && (nivel == VAZIO);
        ent_d    = ent_q;
        if (estado_d == ERRO)
            ent_d = 1'b0;
        else if (nivel == VAZIO || nivel == BAIXO)
            ent_d = 1'b1;
        else if (nivel == CHEIO)
            ent_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            s1_q     <= '0;
            s2_q     <= '0;
            estado_q <= OCIOSO;
            cnt_q    <= '0;
            gote_q   <= 1'b0;
            asp_q    <= 1'b0;
            ent_q    <= 1'b0;
            alarme_q <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            gote_q   <= gote_d;
            asp_q    <= asp_d;
            ent_q    <= ent_d;
            alarme_q <= alarme_d;
            erro_q   <= erro_d;
        end
    end

    assign valvulaGotejamento = gote_q;
    assign valvulaAspersao    = asp_q;
    assign valvulaEntrada     = ent_q;
    assign alarme             = alarme_q;
    assign erroSensor         = erro_q;
    assign estado             = estado_q;
    assign tempoRestante      = cnt_q;
    assign leds               = {alarme_q, ent_q, asp_q, gote_q};

endmodule
